// File: rtl/mc_memsys.sv
// ============================================================================
// Module   : mc_memsys
// Purpose  : Memory-side responder for the multi-cycle CPU's single memory
//            port. It holds the shared instruction/data word RAM and a small
//            memory-mapped register bank (LED, CYCLE, WRCNT, STATUS).
//            Reads are combinational; writes commit on the rising clock edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   adr        in  32   byte address from the CPU
//   MemWrite   in   1   write strobe
//   writedata  in  32   store data
//   readdata   out 32   read data, combinational from adr
//   led        out 16   LED register
//   err        out  1   sticky error flag (STATUS[0])
//   dbg_sel    in  DEPTH_LOG2  RAM word index for debug read
//   dbg_data   out 32   RAM word at dbg_sel, combinational
// Configuration:
//   MCMEM_MMIO_EN  defined   -> MMIO bank at 0xFFFF0000..0xFFFF000C
//                  undefined -> 0xFFFF region unmapped, led tied to 0
// ============================================================================
`default_nettype none

module mc_memsys #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           adr,
  input  logic                  MemWrite,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [15:0]           led,
  output logic                  err,
  input  logic [DEPTH_LOG2-1:0] dbg_sel,
  output logic [31:0]           dbg_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_sel_ram;
  logic                  w_sel_mmio;
  logic                  w_unmapped;
  logic                  w_misal;
  logic                  w_wr_ok;
  logic                  w_ram_we;
  logic                  err_q;
  logic                  err_d;

  // Upper address bits above the RAM size are simply dropped, so RAM aliases.
  assign w_idx      = adr[DEPTH_LOG2+1:2];
  assign w_sel_ram  = (adr[31:16] == 16'h0000);
  assign w_misal    = (adr[1:0] != 2'b00);
  assign w_unmapped = !w_sel_ram && !w_sel_mmio;
  // A write is only ever performed when aligned and out of reset.
  assign w_wr_ok    = MemWrite && !w_misal && !rst;
  assign w_ram_we   = w_wr_ok && w_sel_ram;

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      mem_q[w_idx] <= writedata;
    end
  end

  assign dbg_data = mem_q[dbg_sel];

  // Error flag: set on any unmapped access or a misaligned write; cleared by
  // a W1C write to STATUS. The two can never occur together since STATUS is
  // both mapped and aligned.
  always_comb begin
    err_d = err_q;
    if (w_unmapped || (MemWrite && w_misal)) begin
      err_d = 1'b1;
    end else if (w_wr_ok && w_sel_mmio && (adr[3:2] == 2'd3) && writedata[0]) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef MCMEM_MMIO_EN
  logic [15:0] led_q;
  logic [15:0] led_d;
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;
  logic [31:0] wrcnt_q;
  logic [31:0] wrcnt_d;

  assign w_sel_mmio = (adr[31:16] == 16'hFFFF) && (adr[15:4] == 12'h000);

  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    wrcnt_d = wrcnt_q;
    if (w_ram_we) begin
      wrcnt_d = wrcnt_q + 32'd1;
    end
    if (w_wr_ok && w_sel_mmio && (adr[3:2] == 2'd0)) begin
      led_d = writedata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= 16'h0000;
      cycle_q <= 32'h0000_0000;
      wrcnt_q <= 32'h0000_0000;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
      wrcnt_q <= wrcnt_d;
    end
  end

  assign led = led_q;

  // adr[1:0] is ignored on reads so misaligned reads return the aligned word.
  always_comb begin
    readdata = 32'h0000_0000;
    if (w_sel_ram) begin
      readdata = mem_q[w_idx];
    end else if (w_sel_mmio) begin
      case (adr[3:2])
        2'd0:    readdata = {16'h0000, led_q};
        2'd1:    readdata = cycle_q;
        2'd2:    readdata = wrcnt_q;
        default: readdata = {31'h0, err_q};
      endcase
    end
  end
`else
  logic w_unused_adr;

  assign w_sel_mmio   = 1'b0;
  assign led          = 16'h0000;
  assign w_unused_adr = ^adr[15:2];

  always_comb begin
    readdata = 32'h0000_0000;
    if (w_sel_ram) begin
      readdata = mem_q[w_idx];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_memsys.sv
// ============================================================================
// Module   : tb_mc_memsys
// Purpose  : Self-checking bench for mc_memsys. A behavioural model of the
//            memory map (arrays and plain arithmetic) predicts readdata,
//            dbg_data, led and err for directed and randomized accesses.
// Revision : 1.0 - initial release
// Configuration: honours MCMEM_MMIO_EN the same way as the design.
// ============================================================================
`default_nettype none

module tb_mc_memsys;

  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;
`ifdef MCMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   adr;
  logic          MemWrite;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [15:0]   led;
  logic          err;
  logic [DL-1:0] dbg_sel;
  logic [31:0]   dbg_data;

  always #5 clk = ~clk;

  mc_memsys #(.DEPTH_LOG2(DL)) dut (
    .clk      (clk),
    .rst      (rst),
    .adr      (adr),
    .MemWrite (MemWrite),
    .writedata(writedata),
    .readdata (readdata),
    .led      (led),
    .err      (err),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // Reference model state
  logic [31:0] m_ram [DEPTH];
  bit          m_vld [DEPTH];
  logic [15:0] m_led;
  logic [31:0] m_cycle;
  logic [31:0] m_wrcnt;
  logic        m_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit in_mmio(input logic [31:0] a);
    return MMIO && (a[31:16] == 16'hFFFF) && (a[15:4] == 12'h000);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // One bus cycle: drive, check combinational outputs against the model,
  // clock edge, then advance the model.
  task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic r, input int dsel);
    logic [31:0] exp_rd;
    bit          known;
    bit          is_ram;
    bit          is_mm;
    int          wi;
    rst       = r;
    adr       = a;
    MemWrite  = w;
    writedata = d;
    if (dsel < 0) dbg_sel = DL'($urandom_range(0, DEPTH - 1));
    else          dbg_sel = dsel[DL-1:0];
    #1;
    is_ram = (a[31:16] == 16'h0000);
    is_mm  = in_mmio(a);
    wi     = word_of(a);
    known  = 1'b1;
    exp_rd = 32'h0;
    if (is_ram) begin
      known  = m_vld[wi];
      exp_rd = m_ram[wi];
    end else if (is_mm) begin
      case (a[3:2])
        2'd0:    exp_rd = {16'h0, m_led};
        2'd1:    exp_rd = m_cycle;
        2'd2:    exp_rd = m_wrcnt;
        default: exp_rd = {31'h0, m_err};
      endcase
    end
    if (known) check_eq("readdata", readdata, exp_rd);
    check_eq("err", {31'h0, err}, {31'h0, m_err});
    check_eq("led", {16'h0, led}, {16'h0, m_led});
    if (m_vld[dbg_sel]) check_eq("dbg_data", dbg_data, m_ram[dbg_sel]);
    @(posedge clk);
    if (r) begin
      m_led   = 16'h0;
      m_cycle = 32'h0;
      m_wrcnt = 32'h0;
      m_err   = 1'b0;
    end else begin
      m_cycle = m_cycle + 32'd1;
      if (!is_ram && !is_mm) m_err = 1'b1;
      if (w && (a[1:0] != 2'b00)) begin
        m_err = 1'b1;
      end else if (w) begin
        if (is_ram) begin
          m_ram[wi] = d;
          m_vld[wi] = 1'b1;
          m_wrcnt   = m_wrcnt + 32'd1;
        end else if (is_mm) begin
          if (a[3:2] == 2'd0) m_led = d[15:0];
          else if (a[3:2] == 2'd3 && d[0]) m_err = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] a;
    rst       = 1'b1;
    adr       = 32'h0;
    MemWrite  = 1'b0;
    writedata = 32'h0;
    dbg_sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_ram[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    m_led = 16'h0; m_cycle = 32'h0; m_wrcnt = 32'h0; m_err = 1'b0;

    // Reset state, and a write during reset that must be dropped.
    step(32'hFFFF_0000, 1'b0, 32'h0, 1'b1, 0);
    step(32'hFFFF_0000, 1'b1, 32'h0000_FFFF, 1'b1, 0);
    step(32'hFFFF_000C, 1'b0, 32'h0, 1'b0, 0);

    // Give every RAM word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      step(32'(i * 4), 1'b1, 32'h0, 1'b0, -1);
    end

    // Basic RAM write/read, debug port, WRCNT.
    step(32'h0000_0010, 1'b1, 32'h1234_5678, 1'b0, 4);
    step(32'h0000_0010, 1'b0, 32'h0, 1'b0, 4);
    step(32'hFFFF_0008, 1'b0, 32'h0, 1'b0, 4);

    // LED write/readback, write to read-only CYCLE.
    step(32'hFFFF_0000, 1'b1, 32'h0000_ABCD, 1'b0, -1);
    step(32'hFFFF_0000, 1'b0, 32'h0, 1'b0, -1);
    step(32'hFFFF_0004, 1'b1, 32'h5555_5555, 1'b0, -1);
    step(32'hFFFF_0004, 1'b0, 32'h0, 1'b0, -1);

    // CYCLE counts from reset release.
    step(32'h0000_0010, 1'b0, 32'h0, 1'b1, -1);
    repeat (10) step(32'h0000_0010, 1'b0, 32'h0, 1'b0, -1);
    step(32'hFFFF_0004, 1'b0, 32'h0, 1'b0, -1);
    if (MMIO) check_eq("cycle_after_10", m_cycle, 32'd11);

`ifdef MCMEM_MMIO_EN
    // CYCLE wrap.
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    step(32'hFFFF_0004, 1'b0, 32'h0, 1'b0, -1);
    step(32'hFFFF_0004, 1'b0, 32'h0, 1'b0, -1);
`endif

    // Unmapped write, RAM alias not touched, W1C clear, W0 no effect.
    step(32'h0040_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
    step(32'h0000_0000, 1'b0, 32'h0, 1'b0, 0);
    step(32'hFFFF_000C, 1'b1, 32'h1, 1'b0, -1);
    step(32'hFFFF_000C, 1'b0, 32'h0, 1'b0, -1);
    step(32'h0040_0000, 1'b0, 32'h0, 1'b0, -1);
    step(32'hFFFF_000C, 1'b1, 32'h0, 1'b0, -1);
    step(32'hFFFF_000C, 1'b0, 32'h0, 1'b0, -1);

    // Misaligned write suppressed; misaligned read returns aligned word.
    step(32'hFFFF_000C, 1'b1, 32'h1, 1'b0, -1);
    step(32'h0000_0012, 1'b1, 32'hDEAD_BEEF, 1'b0, 4);
    step(32'h0000_0012, 1'b0, 32'h0, 1'b0, 4);
    step(32'hFFFF_0008, 1'b0, 32'h0, 1'b0, 4);
    step(32'hFFFF_000E, 1'b1, 32'h1, 1'b0, -1);
    step(32'hFFFF_000C, 1'b0, 32'h0, 1'b0, -1);

    // Unmapped inside MMIO window and RAM aliasing.
    step(32'hFFFF_0010, 1'b0, 32'h0, 1'b0, -1);
    step(32'h0000_1010, 1'b1, 32'hA5A5_0001, 1'b0, 4);
    step(32'h0000_0010, 1'b0, 32'h0, 1'b0, 4);

    // Reset mid-sequence drops the pending write.
    step(32'h0000_0020, 1'b1, 32'hCAFE_F00D, 1'b1, 8);
    step(32'h0000_0020, 1'b0, 32'h0, 1'b0, 8);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 5))
        0, 1:    a = {16'h0000, rnd[15:2], 2'b00};
        2:       a = {16'h0000, rnd[15:0]};
        3:       a = {16'hFFFF, 12'h000, rnd[3:0]};
        4:       a = {16'hFFFF, rnd[15:0]};
        default: a = rnd;
      endcase
      step(a, ($urandom_range(0, 1) == 1), $urandom,
           ($urandom_range(0, 99) == 0), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
